regfile_param: RTL and testbench

Parametrised multi-port register file for the lab datapath. It has WIDTH-bit registers, DEPTH entries, two combinational read ports and one opcode-qualified write port gated by debug_en. It adds optional same-cycle write-to-read bypass, an optional hardwired zero register, and a stepped clear sequencer that zeroes the whole file under a busy/done handshake. It sits between instruction decode (op/ra/rb/rd) and the ALU operand inputs; z feeds the debug display.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clear_fsm.sv | 65 ++++++
 rtl/regfile_param.sv | 107 ++++++++++
 tb/tb_regfile_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

  localparam int DEF_WIDTH     = 6;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_OPW       = 3;
  localparam int DEF_WR_OP_MAX = 4;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Stepped clear sequencer: walks an index from 0 to DEPTH-1, one entry per
// debug_en-qualified edge, and reports busy/done from registered state only.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          debug_en,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        // A debug_en-low edge freezes both the state and the index.
        if (debug_en) begin
          if (cnt_q == LAST_IDX) begin
            state_d = CLR_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLR_RUN);
  assign clr_done = (state_q == CLR_DONE);
  assign clr_we   = clr_busy && debug_en;
  assign clr_idx  = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with optional write bypass,
// optional hardwired zero register and a stepped full-file clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = $clog2(DEPTH),
  parameter int OPW       = DEF_OPW,
  parameter int WR_OP_MAX = DEF_WR_OP_MAX,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [OPW-1:0]              op,
  input  logic [AW-1:0]               ra,
  input  logic [AW-1:0]               rb,
  input  logic [AW-1:0]               rd,
  input  logic [WIDTH-1:0]            d,
  input  logic                        debug_en,
  input  logic                        clr_req,
  output logic [WIDTH-1:0]            a,
  output logic [WIDTH-1:0]            b,
  output logic [DEPTH-1:0][WIDTH-1:0] z,
  output logic                        clr_busy,
  output logic                        clr_done
);

  logic          wr;
  logic          clr_we;
  logic [AW-1:0] clr_idx;

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .debug_en (debug_en),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // rd can exceed DEPTH-1 when DEPTH is not a power of two; such writes drop.
  assign wr = debug_en
           && (int'(op) <= WR_OP_MAX)
           && !clr_busy
           && (int'(rd) < DEPTH)
           && !((ZERO_REG != 0) && (rd == '0));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    logic [WIDTH-1:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (clr_we && (clr_idx == AW'(gi))) begin
        entry_d = '0;
      end else if (wr && (rd == AW'(gi))) begin
        entry_d = d;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign z[gi] = entry_q;
  end

  // Decoded mux rather than z[idx] so out-of-range indices fall through to 0.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]               idx,
    input logic [DEPTH-1:0][WIDTH-1:0] regs,
    input logic                        wr_i,
    input logic [AW-1:0]               rd_i,
    input logic [WIDTH-1:0]            d_i
  );
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == AW'(i)) begin
        val = regs[i];
      end
    end
    if ((ZERO_REG != 0) && (idx == '0)) begin
      val = '0;
    end
    if ((BYPASS != 0) && wr_i && (idx == rd_i)) begin
      val = d_i;
    end
    return val;
  endfunction

  always_comb begin
    a = read_port(ra, z, wr, rd, d);
    b = read_port(rb, z, wr, rd, d);
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: two instances (default config and a
// DEPTH=6 / zero-register / no-bypass config) checked against an array model.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] op, ra, rb, rd;
  logic [5:0] d;
  logic       debug_en, clr_req;

  logic [5:0]      a0, b0, a1, b1;
  logic [7:0][5:0] z0;
  logic [5:0][5:0] z1;
  logic            busy0, done0, busy1, done1;

  regfile_param #(
    .WIDTH(6), .DEPTH(8), .OPW(3), .WR_OP_MAX(4), .BYPASS(1), .ZERO_REG(0)
  ) dut0 (
    .clk(clk), .rst(rst), .op(op), .ra(ra), .rb(rb), .rd(rd), .d(d),
    .debug_en(debug_en), .clr_req(clr_req), .a(a0), .b(b0), .z(z0),
    .clr_busy(busy0), .clr_done(done0)
  );

  regfile_param #(
    .WIDTH(6), .DEPTH(6), .OPW(3), .WR_OP_MAX(4), .BYPASS(0), .ZERO_REG(1)
  ) dut1 (
    .clk(clk), .rst(rst), .op(op), .ra(ra), .rb(rb), .rd(rd), .d(d),
    .debug_en(debug_en), .clr_req(clr_req), .a(a1), .b(b1), .z(z1),
    .clr_busy(busy1), .clr_done(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  // Reference model: plain arrays plus a clear phase (0 idle, 1 running, 2 done).
  int mem   [2][8];
  int phase [2];
  int pos   [2];

  logic obs_busy0, obs_done0;

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic bit has_zr(input int k);
    return (k == 1);
  endfunction

  function automatic bit has_byp(input int k);
    return (k == 0);
  endfunction

  function automatic bit m_wr(input int k);
    return debug_en && (int'(op) <= 4) && (phase[k] != 1) && (int'(rd) < dep(k))
           && !(has_zr(k) && (int'(rd) == 0));
  endfunction

  function automatic logic [63:0] m_read(input int k, input int idx);
    if (idx >= dep(k)) return 64'd0;
    if (has_zr(k) && idx == 0) return 64'd0;
    if (has_byp(k) && m_wr(k) && idx == int'(rd)) return {58'd0, d};
    return 64'(mem[k][idx]);
  endfunction

  function automatic logic [63:0] m_z(input int k);
    logic [63:0] e;
    e = 64'd0;
    for (int i = 0; i < dep(k); i++) begin
      e = e | (64'(mem[k][i]) << (i * 6));
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = 0;
      phase[k] = 0;
      pos[k]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit w;
      w = m_wr(k);
      if (w) mem[k][int'(rd)] = int'(d);
      if (phase[k] == 0) begin
        if (clr_req) begin
          phase[k] = 1;
          pos[k]   = 0;
        end
      end else if (phase[k] == 1) begin
        if (debug_en) begin
          mem[k][pos[k]] = 0;
          pos[k] = pos[k] + 1;
          if (pos[k] == dep(k)) phase[k] = 2;
        end
      end else begin
        phase[k] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic sample_all();
    check("a0",    {58'd0, a0},    m_read(0, int'(ra)));
    check("b0",    {58'd0, b0},    m_read(0, int'(rb)));
    check("z0",    {16'd0, z0},    m_z(0));
    check("busy0", {63'd0, busy0}, {63'd0, phase[0] == 1});
    check("done0", {63'd0, done0}, {63'd0, phase[0] == 2});
    check("a1",    {58'd0, a1},    m_read(1, int'(ra)));
    check("b1",    {58'd0, b1},    m_read(1, int'(rb)));
    check("z1",    {28'd0, z1},    m_z(1));
    check("busy1", {63'd0, busy1}, {63'd0, phase[1] == 1});
    check("done1", {63'd0, done1}, {63'd0, phase[1] == 2});
    obs_busy0 = busy0;
    obs_done0 = done0;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic [2:0] op_i, input logic [2:0] ra_i, input logic [2:0] rb_i,
                      input logic [2:0] rd_i, input logic [5:0] d_i, input logic de_i,
                      input logic cr_i);
    op = op_i; ra = ra_i; rb = rb_i; rd = rd_i; d = d_i;
    debug_en = de_i; clr_req = cr_i;
    #1;
    sample_all();
    $display("txn %0d op=%0d ra=%0d rb=%0d rd=%0d d=%02h de=%0b cr=%0b a0=%02h b0=%02h a1=%02h busy0=%0b done0=%0b",
             txn, op_i, ra_i, rb_i, rd_i, d_i, de_i, cr_i, a0, b0, a1, busy0, done0);
    txn++;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2;
    debug_en = 1'b0;
    clr_req  = 1'b0;
    rst      = 1'b0;
    model_reset();
    #1;
    sample_all();
    $display("txn %0d async reset asserted busy0=%0b z0=%012h", txn, busy0, z0);
    txn++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      step(3'd0, 3'(i), 3'(7 - i), 3'(i), 6'(17 + i), 1'b1, 1'b0);
    end
  endtask

  task automatic run_clear(input int drop_a, input int drop_b, input int exp_busy);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen     = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(3'd0, 3'(k % 8), 3'((k + 3) % 8), 3'd3, 6'h3C,
           !(k == drop_a || k == drop_b), (k == 0));
      if (obs_busy0) busy_cnt++;
      if (obs_done0) seen = 1;
    end
    if (!seen) check("clr_timeout", 64'd0, 64'd1);
    check("busy_len", 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin
    rst = 1'b0; op = '0; ra = '0; rb = '0; rd = '0; d = '0;
    debug_en = 1'b0; clr_req = 1'b0;
    model_reset();
    #2;
    sample_all();
    @(negedge clk);
    rst = 1'b1;

    // Preload, then async reset in the middle of ordinary traffic.
    preload();
    step(3'd1, 3'd2, 3'd6, 3'd6, 6'h2B, 1'b1, 1'b0);
    mid_reset();

    // Write with bypass, then a non-writing opcode to the same register.
    step(3'd2, 3'd5, 3'd5, 3'd5, 6'h2A, 1'b1, 1'b0);
    step(3'd5, 3'd5, 3'd0, 3'd5, 6'h01, 1'b1, 1'b0);
    step(3'd0, 3'd5, 3'd1, 3'd0, 6'h00, 1'b0, 1'b0);

    // debug_en gates writes.
    step(3'd0, 3'd1, 3'd1, 3'd1, 6'h07, 1'b1, 1'b0);
    step(3'd0, 3'd1, 3'd1, 3'd1, 6'h15, 1'b0, 1'b0);
    step(3'd0, 3'd1, 3'd2, 3'd1, 6'h15, 1'b1, 1'b0);
    step(3'd0, 3'd1, 3'd2, 3'd2, 6'h00, 1'b0, 1'b0);

    // Zero register and out-of-range indices on the DEPTH=6 instance.
    step(3'd0, 3'd0, 3'd0, 3'd0, 6'h3F, 1'b1, 1'b0);
    step(3'd0, 3'd7, 3'd0, 3'd7, 6'h33, 1'b1, 1'b0);
    step(3'd0, 3'd7, 3'd6, 3'd6, 6'h00, 1'b0, 1'b0);

    // Full clear with debug_en held, then with two stalled cycles.
    preload();
    run_clear(-1, -1, 8);
    step(3'd0, 3'd3, 3'd4, 3'd4, 6'h22, 1'b1, 1'b0);
    preload();
    run_clear(3, 4, 10);

    // Reset partway through a clear, then a fresh clear from index 0.
    preload();
    step(3'd0, 3'd0, 3'd1, 3'd0, 6'h00, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(3'd7, 3'(k), 3'(k + 1), 3'd0, 6'h00, 1'b1, 1'b0);
    mid_reset();
    preload();
    run_clear(-1, -1, 8);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 6'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 15) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
